// File: rtl/mem_bus_arbiter_pkg.sv
// Shared types and widths for the xrv32i memory-port arbiter.
package mem_bus_arbiter_pkg;

  localparam int MemAddressBus = 32;
  localparam int MemBus        = 32;
  localparam int ByteEnBus     = 4;

  // The owner of the transaction is encoded in the state itself.
  typedef enum logic [2:0] {
    ArbIdle  = 3'd0,
    ArbReqI  = 3'd1,
    ArbReqD  = 3'd2,
    ArbWaitI = 3'd3,
    ArbWaitD = 3'd4
  } arb_state_e;

  // One requester's view of a memory command.
  typedef struct packed {
    logic                     we;
    logic [ByteEnBus-1:0]     be;
    logic [MemAddressBus-1:0] addr;
    logic [MemBus-1:0]        wdata;
  } mem_cmd_t;

endpackage

// File: rtl/bus_watchdog.sv
// Counts cycles spent waiting for a memory response and flags expiry on the
// TIMEOUT-th enabled cycle after a clear.
module bus_watchdog #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  logic [7:0] count_q;

  // The first enabled cycle sees count 0, so the TIMEOUT-th sees TIMEOUT-1.
  assign expired = enable && (count_q == 8'(TIMEOUT - 1));

  // Wait-cycle counter; holds once expired until the owner clears it.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge value regardless of block ordering.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count_q <= '0;
    end else if (enable && !expired) begin
      count_q <= count_q + 8'd1;
    end
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares the single memory port between instruction fetch and load/store.
// One transaction outstanding at a time; LSU has priority, bounded by a
// streak limit so fetch always makes progress.
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int MAX_LS_STREAK = 4,
  parameter int TIMEOUT       = 16
) (
  input  logic                     clk,
  input  logic                     rst,

  input  logic                     if_req_in,
  input  logic [MemAddressBus-1:0] if_addr_in,
  output logic                     if_gnt_out,
  output logic                     if_rvalid_out,
  output logic [MemBus-1:0]        if_rdata_out,
  output logic                     if_err_out,

  input  logic                     ls_req_in,
  input  logic                     ls_we_in,
  input  logic [ByteEnBus-1:0]     ls_be_in,
  input  logic [MemAddressBus-1:0] ls_addr_in,
  input  logic [MemBus-1:0]        ls_wdata_in,
  output logic                     ls_gnt_out,
  output logic                     ls_rvalid_out,
  output logic [MemBus-1:0]        ls_rdata_out,
  output logic                     ls_err_out,

  output logic                     mem_req_out,
  output logic                     mem_we_out,
  output logic [ByteEnBus-1:0]     mem_be_out,
  output logic [MemAddressBus-1:0] mem_addr_out,
  output logic [MemBus-1:0]        mem_wdata_out,
  input  logic                     mem_gnt_in,
  input  logic                     mem_rvalid_in,
  input  logic [MemBus-1:0]        mem_rdata_in,

  output logic                     stall_out
);

  localparam int StreakW = $clog2(MAX_LS_STREAK + 1);
  localparam logic [StreakW-1:0] StreakMax = StreakW'(MAX_LS_STREAK);

  arb_state_e         state_q, state_d;
  logic [StreakW-1:0] streak_q;
  logic               in_wait;
  logic               wd_expired;
  logic               ls_wins;
  logic               drive_if;
  logic               drive_ls;
  mem_cmd_t           if_cmd;
  mem_cmd_t           ls_cmd;
  mem_cmd_t           sel_cmd;

  // Fetch carries only an address; its other command fields stay zero.
  assign if_cmd = '{we: 1'b0, be: '0, addr: if_addr_in, wdata: '0};
  assign ls_cmd = '{we: ls_we_in, be: ls_be_in, addr: ls_addr_in, wdata: ls_wdata_in};

  // LSU wins unless fetch is waiting and the LSU streak is exhausted.
  assign ls_wins = ls_req_in && !(if_req_in && (streak_q == StreakMax));

  assign in_wait = (state_q == ArbWaitI) || (state_q == ArbWaitD);

  bus_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk     (clk),
    .rst     (rst),
    .clear   (!in_wait),
    .enable  (in_wait),
    .expired (wd_expired)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ArbIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state, grant/response steering and memory command mux.
  // NOTE: every output of this block is given a default first, so no path
  // through the case statement can leave a value held and infer a latch.
  always_comb begin
    state_d       = state_q;
    drive_if      = 1'b0;
    drive_ls      = 1'b0;
    sel_cmd       = '0;
    if_gnt_out    = 1'b0;
    if_rvalid_out = 1'b0;
    if_rdata_out  = '0;
    if_err_out    = 1'b0;
    ls_gnt_out    = 1'b0;
    ls_rvalid_out = 1'b0;
    ls_rdata_out  = '0;
    ls_err_out    = 1'b0;
    mem_req_out   = 1'b0;
    mem_we_out    = 1'b0;
    mem_be_out    = '0;
    mem_addr_out  = '0;
    mem_wdata_out = '0;
    stall_out     = 1'b0;

    if (!rst) begin
      case (state_q)
        ArbIdle: begin
          if (ls_wins) begin
            drive_ls = 1'b1;
            if (mem_gnt_in) begin
              ls_gnt_out = 1'b1;
              state_d    = ArbWaitD;
            end else begin
              state_d    = ArbReqD;
            end
          end else if (if_req_in) begin
            drive_if = 1'b1;
            if (mem_gnt_in) begin
              if_gnt_out = 1'b1;
              state_d    = ArbWaitI;
            end else begin
              state_d    = ArbReqI;
            end
          end
        end

        ArbReqI: begin
          drive_if = 1'b1;
          if (mem_gnt_in) begin
            if_gnt_out = 1'b1;
            state_d    = ArbWaitI;
          end
        end

        ArbReqD: begin
          drive_ls = 1'b1;
          if (mem_gnt_in) begin
            ls_gnt_out = 1'b1;
            state_d    = ArbWaitD;
          end
        end

        ArbWaitI: begin
          // A response in the expiry cycle takes precedence over the error.
          if (mem_rvalid_in) begin
            if_rvalid_out = 1'b1;
            if_rdata_out  = mem_rdata_in;
            state_d       = ArbIdle;
          end else if (wd_expired) begin
            if_rvalid_out = 1'b1;
            if_err_out    = 1'b1;
            state_d       = ArbIdle;
          end
        end

        ArbWaitD: begin
          if (mem_rvalid_in) begin
            ls_rvalid_out = 1'b1;
            ls_rdata_out  = mem_rdata_in;
            state_d       = ArbIdle;
          end else if (wd_expired) begin
            ls_rvalid_out = 1'b1;
            ls_err_out    = 1'b1;
            state_d       = ArbIdle;
          end
        end

        default: state_d = ArbIdle;
      endcase

      if (drive_ls) begin
        sel_cmd = ls_cmd;
      end else if (drive_if) begin
        sel_cmd = if_cmd;
      end

      mem_req_out   = drive_ls || drive_if;
      mem_we_out    = sel_cmd.we;
      mem_be_out    = sel_cmd.be;
      mem_addr_out  = sel_cmd.addr;
      mem_wdata_out = sel_cmd.wdata;

      // A requester is stalled while it asks or waits, until its response.
      stall_out = ((if_req_in || (state_q == ArbWaitI)) && !if_rvalid_out) ||
                  ((ls_req_in || (state_q == ArbWaitD)) && !ls_rvalid_out);
    end
  end

  // Consecutive LSU grants while fetch is pending; any fetch grant, or an
  // LSU grant with no fetch waiting, restarts the count.
  always_ff @(posedge clk) begin
    if (rst) begin
      streak_q <= '0;
    end else if (if_gnt_out) begin
      streak_q <= '0;
    end else if (ls_gnt_out) begin
      if (!if_req_in) begin
        streak_q <= '0;
      end else if (streak_q != StreakMax) begin
        streak_q <= streak_q + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: inputs change 1 ns after each rising
// edge and outputs are checked 2 ns later, well clear of the next edge.
module tb_mem_bus_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req_in;
  logic [31:0] if_addr_in;
  logic        if_gnt_out, if_rvalid_out, if_err_out;
  logic [31:0] if_rdata_out;
  logic        ls_req_in, ls_we_in;
  logic [3:0]  ls_be_in;
  logic [31:0] ls_addr_in, ls_wdata_in;
  logic        ls_gnt_out, ls_rvalid_out, ls_err_out;
  logic [31:0] ls_rdata_out;
  logic        mem_req_out, mem_we_out;
  logic [3:0]  mem_be_out;
  logic [31:0] mem_addr_out, mem_wdata_out;
  logic        mem_gnt_in, mem_rvalid_in;
  logic [31:0] mem_rdata_in;
  logic        stall_out;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_bus_arbiter #(
    .MAX_LS_STREAK (4),
    .TIMEOUT       (16)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .if_req_in     (if_req_in),
    .if_addr_in    (if_addr_in),
    .if_gnt_out    (if_gnt_out),
    .if_rvalid_out (if_rvalid_out),
    .if_rdata_out  (if_rdata_out),
    .if_err_out    (if_err_out),
    .ls_req_in     (ls_req_in),
    .ls_we_in      (ls_we_in),
    .ls_be_in      (ls_be_in),
    .ls_addr_in    (ls_addr_in),
    .ls_wdata_in   (ls_wdata_in),
    .ls_gnt_out    (ls_gnt_out),
    .ls_rvalid_out (ls_rvalid_out),
    .ls_rdata_out  (ls_rdata_out),
    .ls_err_out    (ls_err_out),
    .mem_req_out   (mem_req_out),
    .mem_we_out    (mem_we_out),
    .mem_be_out    (mem_be_out),
    .mem_addr_out  (mem_addr_out),
    .mem_wdata_out (mem_wdata_out),
    .mem_gnt_in    (mem_gnt_in),
    .mem_rvalid_in (mem_rvalid_in),
    .mem_rdata_in  (mem_rdata_in),
    .stall_out     (stall_out)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic check_bit(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic clear_inputs();
    if_req_in     = 1'b0;
    if_addr_in    = '0;
    ls_req_in     = 1'b0;
    ls_we_in      = 1'b0;
    ls_be_in      = '0;
    ls_addr_in    = '0;
    ls_wdata_in   = '0;
    mem_gnt_in    = 1'b0;
    mem_rvalid_in = 1'b0;
    mem_rdata_in  = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  // All outputs quiet: no grants, responses, memory request or stall.
  task automatic check_quiet(input string tag);
    check({tag, "_resp"},
          {25'd0, if_gnt_out, if_rvalid_out, if_err_out, ls_gnt_out,
           ls_rvalid_out, ls_err_out, mem_req_out}, 32'd0);
    check({tag, "_data"}, if_rdata_out | ls_rdata_out | mem_addr_out | mem_wdata_out, 32'd0);
    check_bit({tag, "_stall"}, stall_out, 1'b0);
  endtask

  initial begin
    clear_inputs();
    rst = 1'b1;
    tick();
    tick();

    // Reset state.
    settle();
    check_quiet("reset");
    rst = 1'b0;
    tick();

    // Fetch only: grant in cycle 0, response in cycle 1.
    if_req_in = 1'b1; if_addr_in = 32'h4; mem_gnt_in = 1'b1;
    settle();
    check_bit("fo_gnt", if_gnt_out, 1'b1);
    check_bit("fo_mreq", mem_req_out, 1'b1);
    check("fo_maddr", mem_addr_out, 32'h4);
    check_bit("fo_stall0", stall_out, 1'b1);
    tick();
    clear_inputs();
    mem_rvalid_in = 1'b1; mem_rdata_in = 32'h00A0_0093;
    settle();
    check_bit("fo_rvalid", if_rvalid_out, 1'b1);
    check("fo_rdata", if_rdata_out, 32'h00A0_0093);
    check_bit("fo_err", if_err_out, 1'b0);
    check_bit("fo_mreq_wait", mem_req_out, 1'b0);
    check_bit("fo_stall1", stall_out, 1'b0);
    tick();
    clear_inputs();
    settle();
    check_quiet("fo_after");
    tick();

    // Simultaneous requests with streak 0: LSU first, then fetch.
    if_req_in = 1'b1; if_addr_in = 32'h8;
    ls_req_in = 1'b1; ls_addr_in = 32'h100; mem_gnt_in = 1'b1;
    settle();
    check_bit("sim_ls_gnt", ls_gnt_out, 1'b1);
    check_bit("sim_if_gnt0", if_gnt_out, 1'b0);
    check("sim_maddr_ls", mem_addr_out, 32'h100);
    tick();
    ls_req_in = 1'b0; mem_gnt_in = 1'b0;
    mem_rvalid_in = 1'b1; mem_rdata_in = 32'h1122_3344;
    settle();
    check_bit("sim_ls_rvalid", ls_rvalid_out, 1'b1);
    check("sim_ls_rdata", ls_rdata_out, 32'h1122_3344);
    check_bit("sim_if_gnt1", if_gnt_out, 1'b0);
    check_bit("sim_stall", stall_out, 1'b1);
    tick();
    mem_rvalid_in = 1'b0; mem_gnt_in = 1'b1;
    settle();
    check_bit("sim_if_gnt2", if_gnt_out, 1'b1);
    check("sim_maddr_if", mem_addr_out, 32'h8);
    tick();
    clear_inputs();
    mem_rvalid_in = 1'b1; mem_rdata_in = 32'h0000_0013;
    settle();
    check_bit("sim_if_rvalid", if_rvalid_out, 1'b1);
    check("sim_if_rdata", if_rdata_out, 32'h0000_0013);
    tick();
    clear_inputs();

    // Starvation: two rounds of exactly four LSU grants then one fetch
    // grant; the second round only repeats if the fetch grant cleared
    // the streak.
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < 4; i++) begin
        clear_inputs();
        if_req_in = 1'b1; if_addr_in = 32'h40;
        ls_req_in = 1'b1; ls_addr_in = 32'h100 + 32'(i * 4); mem_gnt_in = 1'b1;
        settle();
        check_bit($sformatf("stv_ls_gnt_r%0d_%0d", r, i), ls_gnt_out, 1'b1);
        check_bit($sformatf("stv_if_gnt_r%0d_%0d", r, i), if_gnt_out, 1'b0);
        tick();
        mem_gnt_in = 1'b0; mem_rvalid_in = 1'b1; mem_rdata_in = 32'(i);
        settle();
        check($sformatf("stv_ls_rdata_r%0d_%0d", r, i), ls_rdata_out, 32'(i));
        tick();
      end
      clear_inputs();
      if_req_in = 1'b1; if_addr_in = 32'h40;
      ls_req_in = 1'b1; ls_addr_in = 32'h200; mem_gnt_in = 1'b1;
      settle();
      check_bit($sformatf("stv_fetch_gnt_r%0d", r), if_gnt_out, 1'b1);
      check_bit($sformatf("stv_ls_held_r%0d", r), ls_gnt_out, 1'b0);
      check($sformatf("stv_maddr_r%0d", r), mem_addr_out, 32'h40);
      tick();
      if_req_in = 1'b0; mem_gnt_in = 1'b0;
      mem_rvalid_in = 1'b1; mem_rdata_in = 32'hCAFE_0000;
      settle();
      check_bit($sformatf("stv_fetch_rvalid_r%0d", r), if_rvalid_out, 1'b1);
      tick();
    end
    clear_inputs();
    tick();

    // Grant backpressure on an LSU write, with fetch waiting.
    for (int c = 0; c < 4; c++) begin
      clear_inputs();
      if_req_in = 1'b1; if_addr_in = 32'hC;
      ls_req_in = 1'b1; ls_we_in = 1'b1; ls_be_in = 4'hF;
      ls_addr_in = 32'h200; ls_wdata_in = 32'hDEAD_BEEF;
      mem_gnt_in = (c == 3);
      mem_rvalid_in = (c == 1);
      mem_rdata_in = 32'h1234_5678;
      settle();
      check_bit($sformatf("bp_mreq_%0d", c), mem_req_out, 1'b1);
      check_bit($sformatf("bp_mwe_%0d", c), mem_we_out, 1'b1);
      check($sformatf("bp_mbe_%0d", c), 32'(mem_be_out), 32'hF);
      check($sformatf("bp_maddr_%0d", c), mem_addr_out, 32'h200);
      check($sformatf("bp_mwdata_%0d", c), mem_wdata_out, 32'hDEAD_BEEF);
      check_bit($sformatf("bp_ls_gnt_%0d", c), ls_gnt_out, c == 3);
      check_bit($sformatf("bp_if_gnt_%0d", c), if_gnt_out, 1'b0);
      check_bit($sformatf("bp_stray_%0d", c), ls_rvalid_out | if_rvalid_out, 1'b0);
      tick();
    end
    clear_inputs();
    if_req_in = 1'b1; if_addr_in = 32'hC; mem_rvalid_in = 1'b1;
    settle();
    check_bit("bp_wr_done", ls_rvalid_out, 1'b1);
    check_bit("bp_wr_err", ls_err_out, 1'b0);
    tick();
    mem_rvalid_in = 1'b0; mem_gnt_in = 1'b1;
    settle();
    check_bit("bp_if_gnt_after", if_gnt_out, 1'b1);
    tick();
    clear_inputs();
    mem_rvalid_in = 1'b1;
    settle();
    check_bit("bp_if_rvalid", if_rvalid_out, 1'b1);
    tick();
    clear_inputs();

    // Timeout: no response for 16 WAIT cycles gives an error response.
    ls_req_in = 1'b1; ls_addr_in = 32'h300; mem_gnt_in = 1'b1;
    settle();
    check_bit("to_gnt", ls_gnt_out, 1'b1);
    tick();
    for (int k = 1; k <= 16; k++) begin
      clear_inputs();
      mem_rdata_in = 32'hFFFF_FFFF;
      settle();
      check_bit($sformatf("to_rvalid_%0d", k), ls_rvalid_out, k == 16);
      check_bit($sformatf("to_err_%0d", k), ls_err_out, k == 16);
      check($sformatf("to_rdata_%0d", k), ls_rdata_out, 32'd0);
      check_bit($sformatf("to_stall_%0d", k), stall_out, k != 16);
      tick();
    end
    clear_inputs();
    settle();
    check_quiet("to_idle");
    tick();
    mem_rvalid_in = 1'b1; mem_rdata_in = 32'hBAD0_0001;
    settle();
    check_quiet("to_late");
    tick();
    clear_inputs();

    // Response in the expiry cycle wins over the error.
    if_req_in = 1'b1; if_addr_in = 32'h80; mem_gnt_in = 1'b1;
    settle();
    check_bit("tb_gnt", if_gnt_out, 1'b1);
    tick();
    for (int k = 1; k <= 16; k++) begin
      clear_inputs();
      mem_rvalid_in = (k == 16);
      mem_rdata_in = 32'h55;
      settle();
      check_bit($sformatf("tb_rvalid_%0d", k), if_rvalid_out, k == 16);
      check_bit($sformatf("tb_err_%0d", k), if_err_out, 1'b0);
      tick();
    end
    clear_inputs();
    settle();
    check_quiet("tb_after");
    tick();

    // Reset in WAIT_D abandons the transaction.
    ls_req_in = 1'b1; ls_addr_in = 32'h400; mem_gnt_in = 1'b1;
    settle();
    check_bit("rst_ls_gnt", ls_gnt_out, 1'b1);
    tick();
    clear_inputs();
    rst = 1'b1;
    settle();
    check_quiet("rst_during");
    tick();
    rst = 1'b0;
    mem_rvalid_in = 1'b1; mem_rdata_in = 32'hBAD0_0002;
    settle();
    check_quiet("rst_dropped");
    tick();
    clear_inputs();
    if_req_in = 1'b1; if_addr_in = 32'h10; mem_gnt_in = 1'b1;
    settle();
    check_bit("rst_new_gnt", if_gnt_out, 1'b1);
    check("rst_new_maddr", mem_addr_out, 32'h10);
    tick();
    clear_inputs();
    mem_rvalid_in = 1'b1; mem_rdata_in = 32'h0000_0073;
    settle();
    check_bit("rst_new_rvalid", if_rvalid_out, 1'b1);
    check("rst_new_rdata", if_rdata_out, 32'h0000_0073);
    tick();
    clear_inputs();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
